// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED ring control path: ring geometry, colour codes,
// handshake FSM states and the frame payload sent to led_ring_driver.
package led_ctrl_pkg;

    localparam int unsigned NUM_LEDS = 12;
    localparam int unsigned POS_W    = 4;
    localparam int unsigned COLOUR_W = 2;
    localparam int unsigned INT_W    = 8;

    localparam logic [COLOUR_W-1:0] COLOUR_RED   = 2'b01;
    localparam logic [COLOUR_W-1:0] COLOUR_GREEN = 2'b10;
    localparam logic [COLOUR_W-1:0] COLOUR_AMBER = 2'b11;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] WAIT_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] WAIT_DONE = 2'd2;

    typedef struct packed {
        logic [NUM_LEDS-1:0] led_mask;
        logic [COLOUR_W-1:0] colour;
        logic [INT_W-1:0]    intensity;
    } frame_t;

    // Colour sequence skips 00 so the ring is never dark.
    function automatic logic [COLOUR_W-1:0] next_colour(input logic [COLOUR_W-1:0] c);
        case (c)
            COLOUR_RED:   return COLOUR_GREEN;
            COLOUR_GREEN: return COLOUR_AMBER;
            default:      return COLOUR_RED;
        endcase
    endfunction

    function automatic logic [NUM_LEDS-1:0] pos_to_mask(input logic [POS_W-1:0] p);
        return NUM_LEDS'(1) << p;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability filter; output idles high.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 400
) (
    input  logic clk,
    input  logic res_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the output; any agreeing sample restarts.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
            dout  <= 1'b1;
        end else if (sync2_q == dout) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            dout  <= sync2_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rotary_encoder_ctrl.sv
// Rotary encoder front end for led_ring_driver: turns detents and switch clicks into
// position/colour/intensity and hands changed frames to the driver via refresh/busy.
module rotary_encoder_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 400,
    parameter logic [INT_W-1:0] INTENSITY_INIT  = 8'h20,
    parameter logic [INT_W-1:0] INTENSITY_STEP  = 8'h10,
    parameter int unsigned      BUSY_WAIT       = 4
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                enc_a,
    input  logic                enc_b,
    input  logic                enc_sw_n,
    input  logic                busy,
    output logic                refresh,
    output logic [NUM_LEDS-1:0] led_mask,
    output logic [COLOUR_W-1:0] colour,
    output logic [INT_W-1:0]    intensity,
    output logic [POS_W-1:0]    position
);

    localparam int unsigned BW_W = $clog2(BUSY_WAIT + 1);

    logic a_db;
    logic b_db;
    logic sw_db_n;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk(clk), .res_n(res_n), .din(enc_a), .dout(a_db));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk(clk), .res_n(res_n), .din(enc_b), .dout(b_db));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
        .clk(clk), .res_n(res_n), .din(enc_sw_n), .dout(sw_db_n));

    logic                a_prev_q,    a_prev_nxt;
    logic                sw_prev_q,   sw_prev_nxt;
    logic [POS_W-1:0]    pos_q,       pos_nxt;
    logic [COLOUR_W-1:0] colour_w_q,  colour_w_nxt;
    logic [INT_W-1:0]    int_w_q,     int_w_nxt;
    logic                rot_held_q,  rot_held_nxt;
    logic                dirty_q,     dirty_nxt;
    logic [STATE_W-1:0]  state_q,     state_nxt;
    logic [BW_W-1:0]     wait_cnt_q,  wait_cnt_nxt;
    logic                refresh_q,   refresh_nxt;
    frame_t              frame_q,     frame_nxt;

    logic step_c;
    logic cw_c;
    logic held_c;
    logic release_c;
    logic changed_c;

    assign step_c    = a_db & ~a_prev_q;
    assign cw_c      = ~b_db;
    // Held is judged on the previous switch level so a step coinciding with release still adjusts intensity.
    assign held_c    = ~sw_prev_q;
    assign release_c = sw_db_n & ~sw_prev_q;

    always_comb begin
        a_prev_nxt   = a_db;
        sw_prev_nxt  = sw_db_n;
        pos_nxt      = pos_q;
        colour_w_nxt = colour_w_q;
        int_w_nxt    = int_w_q;
        rot_held_nxt = rot_held_q;
        dirty_nxt    = dirty_q;
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        refresh_nxt  = 1'b0;
        frame_nxt    = frame_q;

        if (step_c) begin
            if (held_c) begin
                rot_held_nxt = 1'b1;
                if (cw_c) begin
                    int_w_nxt = (int_w_q > (8'hFF - INTENSITY_STEP)) ? 8'hFF
                                                                     : int_w_q + INTENSITY_STEP;
                end else begin
                    int_w_nxt = (int_w_q < INTENSITY_STEP) ? 8'h00 : int_w_q - INTENSITY_STEP;
                end
            end else if (cw_c) begin
                pos_nxt = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_nxt = (pos_q == '0) ? POS_W'(NUM_LEDS - 1) : pos_q - POS_W'(1);
            end
        end

        if (release_c) begin
            if (!rot_held_q && !step_c) begin
                colour_w_nxt = next_colour(colour_w_q);
            end
            rot_held_nxt = 1'b0;
        end

        changed_c = (pos_nxt != pos_q) || (colour_w_nxt != colour_w_q) || (int_w_nxt != int_w_q);

        case (state_q)
            IDLE: begin
                if (dirty_q && !busy) begin
                    frame_nxt.led_mask  = pos_to_mask(pos_q);
                    frame_nxt.colour    = colour_w_q;
                    frame_nxt.intensity = int_w_q;
                    refresh_nxt         = 1'b1;
                    dirty_nxt           = 1'b0;
                    wait_cnt_nxt        = '0;
                    state_nxt           = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
                    // Driver never acknowledged: treat the frame as lost and resend.
                    dirty_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt_q + BW_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (changed_c) begin
            dirty_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            a_prev_q   <= 1'b1;
            sw_prev_q  <= 1'b1;
            pos_q      <= '0;
            colour_w_q <= COLOUR_RED;
            int_w_q    <= INTENSITY_INIT;
            rot_held_q <= 1'b0;
            dirty_q    <= 1'b1;
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            refresh_q  <= 1'b0;
            frame_q    <= '{led_mask: NUM_LEDS'(1), colour: COLOUR_RED, intensity: INTENSITY_INIT};
        end else begin
            a_prev_q   <= a_prev_nxt;
            sw_prev_q  <= sw_prev_nxt;
            pos_q      <= pos_nxt;
            colour_w_q <= colour_w_nxt;
            int_w_q    <= int_w_nxt;
            rot_held_q <= rot_held_nxt;
            dirty_q    <= dirty_nxt;
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            refresh_q  <= refresh_nxt;
            frame_q    <= frame_nxt;
        end
    end

    assign refresh   = refresh_q;
    assign led_mask  = frame_q.led_mask;
    assign colour    = frame_q.colour;
    assign intensity = frame_q.intensity;
    assign position  = pos_q;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Bench for rotary_encoder_ctrl: directed vector table, corner sequences and random
// encoder activity checked against an action-level model of ring/colour/intensity.
module tb_rotary_encoder_ctrl;
    import led_ctrl_pkg::*;

    localparam int unsigned DEB      = 8;
    localparam int unsigned HOLD     = 20;
    localparam int unsigned BUSY_LEN = 100;

    localparam int A_CW = 0, A_CCW = 1, A_CLICK = 2, A_HOLD_CW = 3, A_HOLD_CCW = 4;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enc_sw_n = 1'b1;
    logic        busy = 1'b0;
    logic        refresh;
    logic [11:0] led_mask;
    logic [1:0]  colour;
    logic [7:0]  intensity;
    logic [3:0]  position;

    rotary_encoder_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .INTENSITY_INIT(8'h20), .INTENSITY_STEP(8'h10), .BUSY_WAIT(4)
    ) dut (
        .clk(clk), .res_n(res_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw_n(enc_sw_n),
        .busy(busy), .refresh(refresh), .led_mask(led_mask), .colour(colour),
        .intensity(intensity), .position(position)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ref_cnt = 0;
    int viol = 0;
    int busy_left = 0;
    bit auto_busy = 1'b1;
    bit prev_ref = 1'b0;

    // Model state, in plain integers.
    int m_pos = 0, m_col = 1, m_int = 32;
    bit m_held = 0, m_rot = 0;

    // Protocol monitor and driver busy model (busy for BUSY_LEN cycles after each refresh).
    initial forever begin
        @(negedge clk);
        if (res_n) begin
            if (refresh) begin
                ref_cnt++;
                if (busy) viol++;
                if (prev_ref) viol++;
            end
            if (!$onehot(led_mask)) viol++;
            if (position >= 4'd12) viol++;
        end
        prev_ref = refresh;
        if (auto_busy) begin
            if (refresh) busy_left = BUSY_LEN;
            else if (busy_left > 0) busy_left--;
            busy = (busy_left > 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void m_step(input bit cw);
        if (m_held) begin
            m_int = cw ? ((m_int + 16 > 255) ? 255 : m_int + 16)
                       : ((m_int - 16 < 0) ? 0 : m_int - 16);
            m_rot = 1;
        end else begin
            m_pos = (m_pos + (cw ? 1 : 11)) % 12;
        end
    endfunction

    function automatic void m_release();
        if (!m_rot) m_col = (m_col == 3) ? 1 : m_col + 1;
        m_rot  = 0;
        m_held = 0;
    endfunction

    task automatic detent(input bit cw);
        @(negedge clk);
        enc_b = !cw;
        tick(HOLD);
        enc_a = 1'b1;
        tick(HOLD);
        enc_a = 1'b0;
        tick(HOLD);
        m_step(cw);
    endtask

    task automatic press();
        @(negedge clk);
        enc_sw_n = 1'b0;
        tick(HOLD);
        m_held = 1;
    endtask

    task automatic release_sw();
        @(negedge clk);
        enc_sw_n = 1'b1;
        tick(HOLD);
        m_release();
    endtask

    task automatic settle(input string name);
        int quiet = 0;
        for (int i = 0; i < 4000 && quiet < 30; i++) begin
            @(negedge clk);
            if (!busy && !refresh) quiet++;
            else quiet = 0;
        end
        if (quiet < 30) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s settle: got timeout expected quiet bus", name);
        end
    endtask

    task automatic check_model(input string name);
        check({name, " position"}, 32'(position), 32'(m_pos));
        check({name, " led_mask"}, 32'(led_mask), 32'(12'(1) << m_pos));
        check({name, " colour"}, 32'(colour), 32'(m_col));
        check({name, " intensity"}, 32'(intensity), 32'(m_int));
    endtask

    typedef struct {
        int         act;
        int         arg;
        int         e_pos;
        logic [11:0] e_mask;
        logic [1:0] e_col;
        logic [7:0] e_int;
        int         e_ref;
    } vec_t;

    vec_t vt[14];

    initial begin
        int r0, p0, n;
        bit found;

        vt[0]  = '{A_CW,       0,  1, 12'h002, 2'd1, 8'h20,  1};
        vt[1]  = '{A_CW,       0,  2, 12'h004, 2'd1, 8'h20,  1};
        vt[2]  = '{A_CW,       0,  3, 12'h008, 2'd1, 8'h20,  1};
        vt[3]  = '{A_CCW,      0,  2, 12'h004, 2'd1, 8'h20,  1};
        vt[4]  = '{A_CCW,      0,  1, 12'h002, 2'd1, 8'h20,  1};
        vt[5]  = '{A_CCW,      0,  0, 12'h001, 2'd1, 8'h20,  1};
        vt[6]  = '{A_CCW,      0, 11, 12'h800, 2'd1, 8'h20,  1};
        vt[7]  = '{A_CW,       0,  0, 12'h001, 2'd1, 8'h20,  1};
        vt[8]  = '{A_CLICK,    0,  0, 12'h001, 2'd2, 8'h20,  1};
        vt[9]  = '{A_CLICK,    0,  0, 12'h001, 2'd3, 8'h20,  1};
        vt[10] = '{A_CLICK,    0,  0, 12'h001, 2'd1, 8'h20,  1};
        vt[11] = '{A_HOLD_CW, 15,  0, 12'h001, 2'd1, 8'hFF, -1};
        vt[12] = '{A_HOLD_CCW, 3,  0, 12'h001, 2'd1, 8'hCF, -1};
        vt[13] = '{A_HOLD_CCW,14,  0, 12'h001, 2'd1, 8'h00, -1};

        // Reset values while held in reset
        tick(3);
        check("reset refresh", 32'(refresh), 32'd0);
        check("reset led_mask", 32'(led_mask), 32'h001);
        check("reset colour", 32'(colour), 32'd1);
        check("reset intensity", 32'(intensity), 32'h20);
        check("reset position", 32'(position), 32'd0);

        // First frame after reset
        res_n = 1'b1;
        found = 0;
        for (int i = 0; i < int'(DEB) + 3 && !found; i++) begin
            @(negedge clk);
            if (refresh) found = 1;
        end
        check("first refresh seen", 32'(found), 32'd1);
        check("first led_mask", 32'(led_mask), 32'h001);
        check("first colour", 32'(colour), 32'd1);
        check("first intensity", 32'(intensity), 32'h20);
        settle("first");
        check("first refresh count", 32'(ref_cnt), 32'd1);

        // Directed vector table
        for (int v = 0; v < 14; v++) begin
            r0 = ref_cnt;
            case (vt[v].act)
                A_CW:    detent(1'b1);
                A_CCW:   detent(1'b0);
                A_CLICK: begin press(); release_sw(); end
                default: begin
                    press();
                    for (int k = 0; k < vt[v].arg; k++) detent(vt[v].act == A_HOLD_CW);
                    release_sw();
                end
            endcase
            settle($sformatf("vec%0d", v));
            check($sformatf("vec%0d position", v), 32'(position), 32'(vt[v].e_pos));
            check($sformatf("vec%0d led_mask", v), 32'(led_mask), 32'(vt[v].e_mask));
            check($sformatf("vec%0d colour", v), 32'(colour), 32'(vt[v].e_col));
            check($sformatf("vec%0d intensity", v), 32'(intensity), 32'(vt[v].e_int));
            if (vt[v].e_ref >= 0)
                check($sformatf("vec%0d refreshes", v), 32'(ref_cnt - r0), 32'(vt[v].e_ref));
        end

        // Short glitch on A is filtered out
        r0 = ref_cnt;
        @(negedge clk);
        enc_b = 1'b0;
        tick(HOLD);
        enc_a = 1'b1;
        tick(5);
        enc_a = 1'b0;
        tick(HOLD);
        settle("glitch");
        check("glitch position", 32'(position), 32'(m_pos));
        check("glitch refreshes", 32'(ref_cnt - r0), 32'd0);

        // Step and switch release land on the same cycle
        press();
        @(negedge clk);
        enc_b = 1'b0;
        tick(HOLD);
        enc_a = 1'b1;
        enc_sw_n = 1'b1;
        tick(HOLD);
        enc_a = 1'b0;
        tick(HOLD);
        m_step(1'b1);
        m_release();
        settle("same_cycle");
        check_model("same_cycle");

        // Random activity against the model
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 3))
                0: detent(1'b1);
                1: detent(1'b0);
                2: begin press(); release_sw(); end
                default: begin
                    press();
                    n = $urandom_range(0, 4);
                    for (int k = 0; k < n; k++) detent(1'($urandom_range(0, 1)));
                    release_sw();
                end
            endcase
            settle($sformatf("rand%0d", it));
            check_model($sformatf("rand%0d", it));
        end

        // Detents while driver busy coalesce into one frame after busy falls
        auto_busy = 1'b0;
        @(negedge clk);
        busy = 1'b1;
        r0 = ref_cnt;
        p0 = m_pos;
        detent(1'b1);
        detent(1'b1);
        check("busy held refreshes", 32'(ref_cnt - r0), 32'd0);
        @(negedge clk);
        busy_left = 0;
        busy = 1'b0;
        auto_busy = 1'b1;
        settle("busy_release");
        check("busy release refreshes", 32'(ref_cnt - r0), 32'd1);
        check("busy release position", 32'(position), 32'((p0 + 2) % 12));
        check_model("busy_release");

        // Driver never raises busy: frame re-sent after the wait window
        auto_busy = 1'b0;
        detent(1'b1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (refresh) found = 1;
        end
        check("no-busy first refresh", 32'(found), 32'd1);
        n = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            n++;
            if (refresh) found = 1;
        end
        check("no-busy resend gap", 32'(n), 32'd5);

        // Reset asserted while waiting for the driver to finish
        auto_busy = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        check("busy raised", 32'(found), 32'd1);
        tick(10);
        res_n = 1'b0;
        #1;
        check("midreset refresh", 32'(refresh), 32'd0);
        check("midreset position", 32'(position), 32'd0);
        check("midreset led_mask", 32'(led_mask), 32'h001);
        check("midreset colour", 32'(colour), 32'd1);
        check("midreset intensity", 32'(intensity), 32'h20);

        check("protocol violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
